// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch for a small 7-bit byte-addressed ROM.
// Three-state control (IDLE -> RUN <-> HALT). A fetch is issued while RUN and
// not stalled, and the returned word is registered into the IF stage on the
// same edge. Branch/jump redirects override stall and halt detection.
// A word equal to HALT_WORD parks the unit in HALT until a redirect arrives.
//
// Optional feature, enabled by defining FETCH_MISALIGN_CHK_EN:
//   A redirect whose target has nonzero low bits sets a sticky misalign_err.
//   Without the macro, misalign_err is tied low. In both builds the low two
//   bits of the target are cleared.
module fetch_unit #(
  parameter logic [6:0]  RESET_PC  = 7'h00,
  parameter logic [31:0] HALT_WORD = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [6:0]  redirect_pc,
  output logic        rom_en,
  output logic [6:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic        if_valid,
  output logic [6:0]  if_pc,
  output logic [31:0] if_instr,
  output logic        halted,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [6:0]  if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;

  // Word-aligned form of a byte address (low two bits forced to zero).
  function automatic logic [6:0] align_pc(input logic [6:0] addr);
    return addr & 7'h7C;
  endfunction

  // Sequential successor; 7-bit arithmetic wraps 0x7C back to 0x00.
  function automatic logic [6:0] next_seq_pc(input logic [6:0] addr);
    return addr + 7'd4;
  endfunction

  // A redirect is honoured everywhere except the single IDLE cycle.
  logic take_redirect;
  assign take_redirect = redirect_valid && (state_q != S_IDLE);

  // State register, PC and IF-stage outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= 7'h00;
      if_instr_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  // Next-state and next-IF-stage decode; holding is the default.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (take_redirect) begin
          pc_d       = align_pc(redirect_pc);
          if_valid_d = 1'b0;
        end else if (!stall) begin
          if_instr_d = rom_data;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          if (rom_data == HALT_WORD) begin
            state_d = S_HALT;
          end else begin
            pc_d = next_seq_pc(pc_q);
          end
        end
      end
      S_HALT: begin
        if (take_redirect) begin
          pc_d       = align_pc(redirect_pc);
          if_valid_d = 1'b0;
          state_d    = S_RUN;
        end else if (!stall) begin
          if_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;

  // Sticky flag: set by any honoured redirect with a non-word-aligned target.
  always_comb begin
    misalign_d = misalign_q;
    if (take_redirect && (redirect_pc[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end
  end

  // Misalignment flag register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign rom_en   = (state_q == S_RUN) && !stall;
  assign rom_addr = pc_q;
  assign halted   = (state_q == S_HALT);
  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic, all
// compared against a behavioural model of the fetch rules kept in this file.
module tb_fetch_unit;

  localparam logic [6:0]  RST_PC = 7'h00;
  localparam logic [31:0] HALT_W = 32'h0010_0073;
`ifdef FETCH_MISALIGN_CHK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [6:0]  redirect_pc;
  logic        rom_en;
  logic [6:0]  rom_addr;
  logic [31:0] rom_data;
  logic        if_valid;
  logic [6:0]  if_pc;
  logic [31:0] if_instr;
  logic        halted;
  logic        misalign_err;

  logic [31:0] rom [32];
  assign rom_data = rom[rom_addr[6:2]];

  int checks = 0;
  int failures = 0;

  // Reference model: plain variables describing what the fetch unit shows.
  bit          m_first;
  bit          m_halted;
  bit          m_vld;
  bit          m_mis;
  logic [6:0]  m_pc;
  logic [6:0]  m_ipc;
  logic [31:0] m_instr;

  fetch_unit #(.RESET_PC(RST_PC), .HALT_WORD(HALT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .halted(halted), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [49:0] obs();
    return {rom_en, rom_addr, if_valid, if_pc, if_instr, halted, misalign_err};
  endfunction

  function automatic logic [49:0] expv();
    logic en;
    en = !m_first && !m_halted && !stall;
    return {en, m_pc, m_vld, m_ipc, m_instr, m_halted, m_mis};
  endfunction

  task automatic model_reset();
    m_first = 1'b1; m_halted = 1'b0; m_vld = 1'b0; m_mis = 1'b0;
    m_pc = RST_PC; m_ipc = 7'h00; m_instr = 32'h0;
  endtask

  // Apply one clock edge of the fetch rules to the model using current inputs.
  task automatic model_next();
    logic [31:0] w;
    int t;
    if (m_first) begin
      m_first = 1'b0;
    end else if (redirect_valid) begin
      m_pc = {redirect_pc[6:2], 2'b00};
      m_vld = 1'b0;
      m_halted = 1'b0;
      if (MIS && redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
    end else if (!stall && !m_halted) begin
      w = rom[int'(m_pc) / 4];
      m_instr = w;
      m_ipc = m_pc;
      m_vld = 1'b1;
      if (w == HALT_W) begin
        m_halted = 1'b1;
      end else begin
        t = (int'(m_pc) + 4) % 128;
        m_pc = t[6:0];
      end
    end else if (!stall) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic apply(input bit st, input bit rv, input logic [6:0] rpc);
    stall = st;
    redirect_valid = rv;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic advance();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 7'h55;
    model_reset();
    #2;
    checks++;
    if (rom_en !== 1'b0 || rom_addr !== RST_PC) begin
      failures++;
      $display("FAIL reset_rom got en=%b addr=%h exp en=0 addr=%h", rom_en, rom_addr, RST_PC);
    end
    checks++;
    if (if_valid !== 1'b0 || if_pc !== 7'h00 || if_instr !== 32'h0) begin
      failures++;
      $display("FAIL reset_if got v=%b pc=%h instr=%h exp 0/00/00000000", if_valid, if_pc, if_instr);
    end
    checks++;
    if (halted !== 1'b0 || misalign_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got halted=%b mis=%b exp 0/0", halted, misalign_err);
    end
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (obs() !== expv()) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=%h", obs(), expv());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int k = 0; k < 3; k++) begin
      if (k == 0) apply(1'b1, 1'b1, 7'h40);
      else apply(1'b0, 1'b0, 7'h00);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL basic k=%0d got=%h exp=%h", k, obs(), expv());
      end
      checks++;
      if ((k == 0 && (rom_en !== 1'b0 || rom_addr !== RST_PC)) ||
          (k == 1 && (rom_en !== 1'b1 || rom_addr !== 7'h00 || if_valid !== 1'b0)) ||
          (k == 2 && (if_valid !== 1'b1 || if_pc !== 7'h00 || if_instr !== 32'h0))) begin
        failures++;
        $display("FAIL basic_seq k=%0d got en=%b addr=%h v=%b pc=%h instr=%h", k, rom_en, rom_addr, if_valid, if_pc, if_instr);
      end
      advance();
    end
    apply(1'b0, 1'b0, 7'h00);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 7'h04 || if_instr !== 32'h0034_8493) begin
      failures++;
      $display("FAIL basic_pc4 got v=%b pc=%h instr=%h exp 1/04/00348493", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 7'h00);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL stall i=%0d got=%h exp=%h", i, obs(), expv());
      end
      checks++;
      if (if_pc !== 7'h04 || if_instr !== 32'h0034_8493 || rom_en !== 1'b0 || rom_addr !== 7'h08) begin
        failures++;
        $display("FAIL stall_hold i=%0d got pc=%h instr=%h en=%b addr=%h exp 04/00348493/0/08", i, if_pc, if_instr, rom_en, rom_addr);
      end
      advance();
    end
    apply(1'b0, 1'b0, 7'h00);
    checks++;
    if (if_pc !== 7'h04 || if_valid !== 1'b1 || rom_en !== 1'b1) begin
      failures++;
      $display("FAIL stall_after got pc=%h v=%b en=%b exp 04/1/1", if_pc, if_valid, rom_en);
    end
    advance();
    apply(1'b0, 1'b0, 7'h00);
    checks++;
    if (if_pc !== 7'h08 || if_instr !== 32'h0011_8193 || rom_addr !== 7'h0C) begin
      failures++;
      $display("FAIL stall_resume got pc=%h instr=%h addr=%h exp 08/00118193/0c", if_pc, if_instr, rom_addr);
    end
  endtask

  task automatic test_redirect();
    apply(1'b1, 1'b1, 7'h08);
    checks++;
    if (obs() !== expv() || rom_addr !== 7'h0C) begin
      failures++;
      $display("FAIL redir_pre got=%h exp=%h", obs(), expv());
    end
    advance();
    apply(1'b0, 1'b0, 7'h00);
    checks++;
    if (if_valid !== 1'b0 || rom_addr !== 7'h08) begin
      failures++;
      $display("FAIL redir_load got v=%b addr=%h exp 0/08", if_valid, rom_addr);
    end
    advance();
    apply(1'b0, 1'b0, 7'h00);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 7'h08 || if_instr !== 32'h0011_8193) begin
      failures++;
      $display("FAIL redir_fetch got v=%b pc=%h instr=%h exp 1/08/00118193", if_valid, if_pc, if_instr);
    end
    checks++;
    if (obs() !== expv()) begin
      failures++;
      $display("FAIL redir_model got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_wrap();
    logic [31:0] last_word;
    last_word = rom[31];
    apply(1'b0, 1'b1, 7'h7C);
    advance();
    apply(1'b0, 1'b0, 7'h00);
    checks++;
    if (rom_addr !== 7'h7C || rom_en !== 1'b1) begin
      failures++;
      $display("FAIL wrap_pre got addr=%h en=%b exp 7c/1", rom_addr, rom_en);
    end
    advance();
    apply(1'b0, 1'b0, 7'h00);
    checks++;
    if (rom_addr !== 7'h00 || if_pc !== 7'h7C || if_instr !== last_word) begin
      failures++;
      $display("FAIL wrap got addr=%h pc=%h instr=%h exp 00/7c/%h", rom_addr, if_pc, if_instr, last_word);
    end
    checks++;
    if (obs() !== expv()) begin
      failures++;
      $display("FAIL wrap_model got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_halt();
    apply(1'b0, 1'b1, 7'h10);
    advance();
    apply(1'b0, 1'b1, 7'h20);
    advance();
    apply(1'b0, 1'b0, 7'h00);
    checks++;
    if (halted !== 1'b0 || rom_addr !== 7'h20 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_redir_prio got halted=%b addr=%h v=%b exp 0/20/0", halted, rom_addr, if_valid);
    end
    apply(1'b0, 1'b1, 7'h10);
    advance();
    apply(1'b0, 1'b0, 7'h00);
    checks++;
    if (rom_addr !== 7'h10 || rom_en !== 1'b1) begin
      failures++;
      $display("FAIL halt_pre got addr=%h en=%b exp 10/1", rom_addr, rom_en);
    end
    advance();
    apply(1'b1, 1'b0, 7'h00);
    checks++;
    if (if_instr !== 32'h0010_0073 || if_valid !== 1'b1 || halted !== 1'b1 || rom_en !== 1'b0 || if_pc !== 7'h10) begin
      failures++;
      $display("FAIL halt_capture got instr=%h v=%b halted=%b en=%b pc=%h exp 00100073/1/1/0/10", if_instr, if_valid, halted, rom_en, if_pc);
    end
    advance();
    apply(1'b0, 1'b0, 7'h00);
    checks++;
    if (if_valid !== 1'b1 || halted !== 1'b1 || rom_en !== 1'b0) begin
      failures++;
      $display("FAIL halt_stallhold got v=%b halted=%b en=%b exp 1/1/0", if_valid, halted, rom_en);
    end
    advance();
    apply(1'b0, 1'b0, 7'h00);
    checks++;
    if (if_valid !== 1'b0 || halted !== 1'b1 || rom_en !== 1'b0 || rom_addr !== 7'h10) begin
      failures++;
      $display("FAIL halt_state got v=%b halted=%b en=%b addr=%h exp 0/1/0/10", if_valid, halted, rom_en, rom_addr);
    end
    advance();
    apply(1'b0, 1'b1, 7'h00);
    advance();
    apply(1'b0, 1'b0, 7'h00);
    checks++;
    if (halted !== 1'b0 || rom_addr !== 7'h00 || rom_en !== 1'b1 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_exit got halted=%b addr=%h en=%b v=%b exp 0/00/1/0", halted, rom_addr, rom_en, if_valid);
    end
    advance();
    apply(1'b0, 1'b0, 7'h00);
    checks++;
    if (if_pc !== 7'h00 || if_valid !== 1'b1 || obs() !== expv()) begin
      failures++;
      $display("FAIL halt_refetch got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_misalign();
    apply(1'b1, 1'b1, 7'h06);
    advance();
    apply(1'b0, 1'b0, 7'h00);
    checks++;
    if (rom_addr !== 7'h04 || misalign_err !== MIS) begin
      failures++;
      $display("FAIL misalign got addr=%h mis=%b exp 04/%b", rom_addr, misalign_err, MIS);
    end
    for (int i = 0; i < 3; i++) begin
      advance();
      apply(1'b0, 1'b0, 7'h00);
      checks++;
      if (misalign_err !== MIS || obs() !== expv()) begin
        failures++;
        $display("FAIL misalign_sticky i=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    apply(1'b0, 1'b1, 7'h20);
    advance();
    apply(1'b0, 1'b0, 7'h00);
    checks++;
    if (misalign_err !== MIS || rom_addr !== 7'h20) begin
      failures++;
      $display("FAIL misalign_aligned got mis=%b addr=%h exp %b/20", misalign_err, rom_addr, MIS);
    end
  endtask

  task automatic test_reset_midfetch();
    apply(1'b0, 1'b0, 7'h00);
    advance();
    apply(1'b0, 1'b0, 7'h00);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rom_en !== 1'b0 || rom_addr !== RST_PC || if_valid !== 1'b0 || if_pc !== 7'h00 ||
        if_instr !== 32'h0 || halted !== 1'b0 || misalign_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got en=%b addr=%h v=%b pc=%h instr=%h h=%b mis=%b exp all zero", rom_en, rom_addr, if_valid, if_pc, if_instr, halted, misalign_err);
    end
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 7'h00);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL reset_mid_run i=%0d got=%h exp=%h", i, obs(), expv());
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 32; i++) begin
      rom[i] = (($urandom % 8) == 0) ? HALT_W : ($urandom | 32'h1);
    end
    for (int i = 0; i < 600; i++) begin
      apply(($urandom % 10) < 3, ($urandom % 10) == 0, 7'($urandom));
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL random i=%0d got=%h exp=%h", i, obs(), expv());
      end
      advance();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rom[i] = $urandom | 32'h1;
      if (rom[i] == HALT_W) rom[i] = rom[i] ^ 32'h2;
    end
    rom[0] = 32'h0000_0000;
    rom[1] = 32'h0034_8493;
    rom[2] = 32'h0011_8193;
    rom[4] = HALT_W;
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_misalign();
    test_reset_midfetch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001: Parameter RESET_PC, default 7'h00, byte address fetched first after reset.
REQ-002: Parameter HALT_WORD, default 32'h0010_0073 (ebreak), instruction word that halts fetch.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: stall  input  1  downstream busy; hold PC and IF outputs.
REQ-006: redirect_valid  input  1  branch/jump taken; load new PC.
REQ-007: redirect_pc  input  7  byte target address for redirect.
REQ-008: rom_en  output  1  read enable to the instruction ROM.
REQ-009: rom_addr  output  7  byte address to the ROM; always equals internal pc_q.
REQ-010: rom_data  input  32  ROM read data, combinational from rom_addr in the same cycle.
REQ-011: if_valid  output  1  if_instr/if_pc hold a valid fetched instruction.
REQ-012: if_pc  output  7  byte address of if_instr.
REQ-013: if_instr  output  32  registered instruction word.
REQ-014: halted  output  1  high while in HALT state.
REQ-015: misalign_err  output  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-016: FSM states IDLE, RUN, HALT; IDLE lasts exactly one cycle after reset release, then RUN.
REQ-017: rom_en = 1 only in RUN with stall=0; 0 in IDLE, HALT, or when stalled.
REQ-018: RUN, stall=0, redirect_valid=0: at edge, if_instr<=rom_data, if_pc<=pc_q, if_valid<=1, pc_q<=pc_q+4.
REQ-019: PC arithmetic is 7-bit modulo 128; pc_q 7'h7C + 4 wraps to 7'h00.
REQ-020: redirect_valid has priority over stall and over halt detection: at edge pc_q<={redirect_pc[6:2],2'b00}, if_valid<=0, no capture.
REQ-021: RUN, stall=1, redirect_valid=0: pc_q, if_valid, if_pc, if_instr all hold.
REQ-022: Capture of rom_data==HALT_WORD: word captured with if_valid=1, pc_q holds, next state HALT.
REQ-023: HALT: halted=1; if_valid clears on the first HALT edge with stall=0, else holds until stall drops; pc_q holds.
REQ-024: HALT with redirect_valid=1: load redirect target per REQ-020, next state RUN, halted=0 next cycle.
REQ-025: IDLE ignores stall and redirect_valid.
REQ-026: Fetch latency: instruction at address A appears on if_instr one edge after rom_addr=A in RUN unstalled.

Reset
REQ-027: rst_n low asynchronously forces state IDLE, pc_q=RESET_PC, if_valid=0, if_pc=0, if_instr=0, halted=0, misalign_err=0, rom_en=0.
REQ-028: Reset asserted mid-fetch discards any in-flight capture; no partial update survives.

Configuration
REQ-029: Macro FETCH_MISALIGN_CHK_EN defined: redirect with redirect_pc[1:0]!=0 sets misalign_err=1 at that edge, sticky until reset; redirect still proceeds with low bits cleared.
REQ-030: Macro undefined: misalign_err tied 0; low redirect bits silently cleared.

Verification
REQ-031: Reset release, ROM words 0x0,0x00348493,0x00118193 at 0,4,8 -> IDLE one cycle, then if_pc 0,4,8 on consecutive cycles, if_valid=1 from the cycle after rom_addr=0.
REQ-032: stall=1 for 3 cycles while if_pc=4 -> if_pc=4, if_instr=0x00348493 held, rom_en=0; resumes with if_pc=8.
REQ-033: redirect_valid=1, redirect_pc=8 together with stall=1 while pc_q=0x0C -> next cycle if_valid=0, rom_addr=8; following edge if_pc=8.
REQ-034: pc_q=0x7C unstalled -> next rom_addr=0x00, if_pc=0x7C.
REQ-035: HALT_WORD at 0x10 -> if_instr=0x00100073 with if_valid=1, then halted=1, if_valid=0, rom_en=0; redirect_pc=0 -> RUN, fetch from 0.
REQ-036: With FETCH_MISALIGN_CHK_EN, redirect_pc=0x06 -> misalign_err=1 sticky, rom_addr=0x04; without macro, misalign_err stays 0.
